// File: rtl/gcd_operand_pairer.sv
// Pairs consecutive operands from a serial stream into {A, B} requests for the GCD unit.
// Optional pair counter output is enabled by defining GCD_OPERAND_PAIRER_COUNT_EN.
module gcd_operand_pairer #(
    parameter int p_nbits = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 istream_val,
    output logic                 istream_rdy,
    input  logic [p_nbits-1:0]   istream_msg,
    input  logic                 abort,
    output logic                 ostream_val,
    input  logic                 ostream_rdy,
`ifdef GCD_OPERAND_PAIRER_COUNT_EN
    output logic [2*p_nbits-1:0] ostream_msg,
    output logic [15:0]          pair_count
`else
    output logic [2*p_nbits-1:0] ostream_msg
`endif
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [p_nbits-1:0] a_q, a_d;
    logic [p_nbits-1:0] b_q, b_d;
    logic               req_go;
    logic               resp_go;

    // In S_OUT the input is ready exactly when the held pair drains, so a new A
    // can be taken in the same cycle the output register empties.
    always_comb begin
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        case (state_q)
            S_A:     istream_rdy = 1'b1;
            S_B:     istream_rdy = !abort;
            S_OUT: begin
                ostream_val = 1'b1;
                istream_rdy = ostream_rdy;
            end
            default: istream_rdy = 1'b0;
        endcase
        if (reset) begin
            istream_rdy = 1'b0;
            ostream_val = 1'b0;
        end
    end

    assign req_go      = istream_val & istream_rdy;
    assign resp_go     = ostream_val & ostream_rdy;
    assign ostream_msg = {a_q, b_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_A: begin
                if (req_go) begin
                    a_d     = istream_msg;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (abort) begin
                    state_d = S_A;
                end else if (req_go) begin
                    b_d     = istream_msg;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (resp_go) begin
                    if (req_go) begin
                        a_d     = istream_msg;
                        state_d = S_B;
                    end else begin
                        state_d = S_A;
                    end
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef GCD_OPERAND_PAIRER_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (resp_go) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pair_count = count_q;
`endif

endmodule
